fifo_tx_serializer: RTL and testbench
=====================================

FIFO_TX_SERIALIZER -- requirements
Module: fifo_tx_serializer

Interface
REQ-001 Parameter BIT_CYCLES, default 4: clock cycles per serial bit; legal range 2..255.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 tx_en  input  1  permits starting a new frame; sampled only in IDLE.
REQ-005 empty  input  1  upstream FIFO empty flag.
REQ-006 get_data  input  8  upstream FIFO head byte; valid whenever empty=0.
REQ-007 get  output  1  FIFO pop strobe; exactly one cycle per byte consumed.
REQ-008 tx_line  output  1  serial output, registered; idle level 1.
REQ-009 tx_busy  output  1  high in every state except IDLE.
REQ-010 tx_done  output  1  one-cycle pulse on the final cycle of each stop bit.
REQ-011 byte_count  output  9  count of completed frames.

Function
REQ-012 FSM states SHALL be IDLE, START, DATA and STOP, with an 8-bit cycle counter and a 3-bit bit index.
REQ-013 get SHALL be a combinational decode: (state==IDLE) & tx_en & ~empty & ~rst.
REQ-014 On the edge where get=1, get_data SHALL be latched into the shift register and the state SHALL go to START.
REQ-015 tx_line SHALL be 0 from the first cycle after the get cycle, for BIT_CYCLES cycles (start bit).
REQ-016 DATA SHALL send 8 bits LSB first, each held for BIT_CYCLES cycles.
REQ-017 STOP SHALL drive tx_line=1 for BIT_CYCLES cycles, then the state SHALL return to IDLE.
REQ-018 A frame SHALL occupy exactly 10*BIT_CYCLES cycles from START entry to IDLE entry.
REQ-019 IDLE SHALL last at least one cycle, so the back-to-back frame period is 10*BIT_CYCLES+1 cycles.
REQ-020 tx_line SHALL be 1 in IDLE.
REQ-021 tx_en deassertion mid-frame SHALL NOT affect the current frame; it only blocks the next start.
REQ-022 Changes on empty or get_data outside the get cycle SHALL be ignored.
REQ-023 get SHALL never assert while empty=1, while not in IDLE, or while rst=1.
REQ-024 byte_count SHALL increment by 1 on the tx_done cycle's edge and wrap from 511 to 0.
REQ-025 The cycle counter SHALL count 0..BIT_CYCLES-1 and reset to 0 at every bit boundary.

Reset
REQ-026 With rst=1 at a clock edge, the next state SHALL be: state IDLE, tx_line 1, tx_busy 0, tx_done 0, byte_count 0, cycle counter 0, bit index 0, shift register 0.
REQ-027 Reset mid-frame SHALL abort the frame without a tx_done pulse; the aborted byte is already popped and is lost.
REQ-028 The first get after reset release SHALL occur no earlier than the first cycle with rst=0.

Verification (BIT_CYCLES=4)
REQ-029 Single byte:
- Stimulus: FIFO holds 0xA5, tx_en=1.
- Response: one get pulse; tx_line = 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; tx_done at cycle 40 after get; byte_count=1.
REQ-030 Empty FIFO:
- Stimulus: empty=1, tx_en=1 for 100 cycles.
- Response: get=0, tx_line=1, tx_busy=0 throughout.
REQ-031 Back-to-back:
- Stimulus: 3 bytes queued (0x00, 0xFF, 0x3C).
- Response: get pulses 41 cycles apart; three frames with correct bit patterns; byte_count=3.
REQ-032 Reset mid-frame:
- Stimulus: assert rst during DATA bit 3.
- Response: next cycle tx_line=1, tx_busy=0, byte_count=0, no tx_done; with tx_en=1 and the FIFO non-empty, the next byte starts after release.
REQ-033 tx_en gating:
- Stimulus: drop tx_en in the middle of a frame.
- Response: the frame completes with tx_done; no further get until tx_en=1 again.
REQ-034 Counter wrap:
- Stimulus: 512 frames sent.
- Response: byte_count reads 511 after frame 511 and 0 after frame 512.

Source files
------------

// File: rtl/fifo_tx_serializer.sv
// Byte-to-serial transmitter fed from an upstream FIFO.
// Each frame is a start bit (0), eight data bits LSB first and a stop bit (1),
// with every bit held for BIT_CYCLES clocks.
module fifo_tx_serializer #(
    parameter int unsigned BIT_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_en,
    input  logic       empty,
    input  logic [7:0] get_data,
    output logic       get,
    output logic       tx_line,
    output logic       tx_busy,
    output logic       tx_done,
    output logic [8:0] byte_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_e;

    localparam int unsigned CNT_W = 8;
    localparam int unsigned IDX_W = 3;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned BCNT_W = 9;

    // Last cycle of a bit, and the cycle just before it (tx_done is registered).
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DONE_AT  = CNT_W'(BIT_CYCLES - 2);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    bit_q, bit_d;
    logic [BYTE_W-1:0]   shift_q, shift_d;
    logic                tx_line_q, tx_line_d;
    logic                tx_busy_q, tx_busy_d;
    logic                tx_done_q, tx_done_d;
    logic [BCNT_W-1:0]   count_q, count_d;
    logic                cnt_last;

    assign cnt_last = (cnt_q == CNT_LAST);

    // Pop strobe: only from IDLE, when enabled, data present and not in reset.
    assign get = (state_q == IDLE) & tx_en & ~empty & ~rst;

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        count_d   = count_q;
        tx_done_d = 1'b0;
        tx_line_d = 1'b1;
        tx_busy_d = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                bit_d = '0;
                if (get) begin
                    shift_d = get_data;
                    state_d = START;
                end
            end
            START: begin
                if (cnt_last) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt_last) begin
                    cnt_d = '0;
                    if (bit_q == IDX_W'(7)) begin
                        state_d = STOP;
                    end else begin
                        bit_d   = bit_q + IDX_W'(1);
                        shift_d = {1'b0, shift_q[BYTE_W-1:1]};
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STOP: begin
                tx_done_d = (cnt_q == DONE_AT);
                if (cnt_last) begin
                    cnt_d   = '0;
                    count_d = count_q + BCNT_W'(1);
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Line level follows the state being entered so tx_line stays registered.
        case (state_d)
            START:   tx_line_d = 1'b0;
            DATA:    tx_line_d = shift_d[0];
            default: tx_line_d = 1'b1;
        endcase
        tx_busy_d = (state_d != IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            count_q   <= '0;
            tx_line_q <= 1'b1;
            tx_busy_q <= 1'b0;
            tx_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            count_q   <= count_d;
            tx_line_q <= tx_line_d;
            tx_busy_q <= tx_busy_d;
            tx_done_q <= tx_done_d;
        end
    end

    assign tx_line    = tx_line_q;
    assign tx_busy    = tx_busy_q;
    assign tx_done    = tx_done_q;
    assign byte_count = count_q;

endmodule

// File: tb/tb_fifo_tx_serializer.sv
// Directed bench for fifo_tx_serializer with BIT_CYCLES=4 and a queue-based FIFO model.
module tb_fifo_tx_serializer;

    localparam int unsigned BC = 4;
    localparam int FRAME = 10 * BC;

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_en;
    logic       empty;
    logic [7:0] get_data;
    logic       get;
    logic       tx_line;
    logic       tx_busy;
    logic       tx_done;
    logic [8:0] byte_count;

    logic [7:0] fifo[$];
    logic       rst_nx, tx_en_nx;
    logic       s_get = 1'b0, s_line, s_busy, s_done;
    logic [8:0] s_cnt;
    logic [8:0] exp_count;
    int         checks = 0;
    int         errors = 0;
    int         cyc_n = 0;
    int         t0;
    int         guard;

    always #5 clk = ~clk;

    fifo_tx_serializer #(.BIT_CYCLES(BC)) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_en      (tx_en),
        .empty      (empty),
        .get_data   (get_data),
        .get        (get),
        .tx_line    (tx_line),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .byte_count (byte_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc_n);
        end
    endtask

    task automatic refresh();
        empty    = (fifo.size() == 0);
        get_data = empty ? 8'h00 : fifo[0];
    endtask

    // One clock: pop if the last cycle popped, apply staged inputs, sample mid-cycle.
    task automatic cyc();
        @(posedge clk);
        #1;
        if (s_get) void'(fifo.pop_front());
        rst   = rst_nx;
        tx_en = tx_en_nx;
        refresh();
        @(negedge clk);
        s_get  = get;
        s_line = tx_line;
        s_busy = tx_busy;
        s_done = tx_done;
        s_cnt  = byte_count;
        cyc_n++;
    endtask

    task automatic wait_get(input int bound);
        for (int i = 0; i < bound && !s_get; i++) cyc();
        chk("wait_get", 32'(s_get), 32'd1);
    endtask

    // Called in the get cycle; checks the 40 frame cycles and the following IDLE cycle.
    task automatic frame(input logic [7:0] b, input int drop_at, input int abort_at);
        logic exp_line;
        int   idx;
        for (int k = 1; k <= FRAME; k++) begin
            cyc();
            idx = (k - 1) / BC;
            if (idx == 0)      exp_line = 1'b0;
            else if (idx == 9) exp_line = 1'b1;
            else               exp_line = b[idx-1];
            chk("frame_bit", {28'd0, s_get, s_busy, s_done, s_line},
                {28'd0, 1'b0, 1'b1, (k == FRAME), exp_line});
            if (k == drop_at) tx_en_nx = 1'b0;
            if (k == abort_at) begin
                rst_nx = 1'b1;
                return;
            end
        end
        exp_count++;
        cyc();
        chk("idle_after_frame", {29'd0, s_busy, s_done, s_line}, 32'b001);
        chk("byte_count", 32'(s_cnt), 32'(exp_count));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; rst_nx = 1'b1;
        tx_en = 1'b1; tx_en_nx = 1'b1;
        fifo.push_back(8'hA5);
        refresh();
        exp_count = '0;

        // Reset holds outputs and blocks get even with data present.
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("reset_out", {28'd0, s_get, s_busy, s_done, s_line}, 32'b0001);
            chk("reset_cnt", 32'(s_cnt), 32'd0);
        end

        // Single byte 0xA5: get in the first cycle with rst=0.
        rst_nx = 1'b0;
        cyc();
        chk("get_after_rst", 32'(s_get), 32'd1);
        frame(fifo[0], 0, 0);

        // Empty FIFO for 100 cycles.
        for (int i = 0; i < 100; i++) begin
            cyc();
            chk("empty_idle", {29'd0, s_get, s_line, s_busy}, 32'b010);
        end

        // Back-to-back 0x00, 0xFF, 0x3C.
        fifo.push_back(8'h00);
        fifo.push_back(8'hFF);
        fifo.push_back(8'h3C);
        wait_get(5);
        for (int i = 0; i < 3; i++) begin
            t0 = cyc_n;
            frame(fifo[0], 0, 0);
            if (i < 2) begin
                chk("b2b_get", 32'(s_get), 32'd1);
                chk("b2b_period", 32'(cyc_n - t0), 32'd41);
            end
        end

        // tx_en dropped mid-frame: frame completes, next start waits for tx_en.
        fifo.push_back(8'h5A);
        fifo.push_back(8'h77);
        wait_get(5);
        frame(fifo[0], 10, 0);
        chk("gate_no_get", 32'(s_get), 32'd0);
        for (int i = 0; i < 20; i++) begin
            cyc();
            chk("gate_hold", {30'd0, s_get, s_busy}, 32'b00);
        end
        tx_en_nx = 1'b1;
        cyc();
        chk("gate_resume", 32'(s_get), 32'd1);
        frame(fifo[0], 0, 0);

        // Reset during DATA bit 3 (frame cycle 18), then restart with the next byte.
        fifo.push_back(8'hC3);
        fifo.push_back(8'h81);
        wait_get(5);
        frame(fifo[0], 0, 18);
        cyc();
        chk("rst_cycle", {29'd0, s_get, s_busy, s_done}, 32'b010);
        rst_nx = 1'b0;
        exp_count = '0;
        cyc();
        chk("abort_out", {29'd0, s_busy, s_done, s_line}, 32'b001);
        chk("abort_cnt", 32'(s_cnt), 32'd0);
        chk("abort_restart", 32'(s_get), 32'd1);
        chk("abort_next_byte", 32'(fifo[0]), 32'h81);
        frame(fifo[0], 0, 0);

        // Run frames until byte_count reaches 511, then one more to wrap to 0.
        guard = 0;
        while (exp_count != 9'd511 && guard < 600) begin
            fifo.push_back(8'($urandom_range(0, 255)));
            cyc();
            wait_get(3);
            frame(fifo[0], 0, 0);
            guard++;
        end
        chk("count_511", 32'(s_cnt), 32'd511);
        fifo.push_back(8'h96);
        cyc();
        wait_get(3);
        frame(fifo[0], 0, 0);
        chk("count_wrap", 32'(s_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
